// File: rtl/hilo_muldiv_unit_if.sv
// Request/response bundle between the execute stage and the HI/LO multiply unit.
// The execute stage drives master; the unit implements slave.
interface hilo_muldiv_unit_if;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  modport master (output Start, Op, A, B, input Busy, Done, Hi, Lo);
  modport slave  (input Start, Op, A, B, output Busy, Done, Hi, Lo);
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative shift-add multiply/accumulate unit owning the architectural HI/LO pair.
// Define HILO_MADDU_EN to decode Op 110/111 as unsigned maddu/msubu.
module hilo_muldiv_unit #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  hilo_muldiv_unit_if.slave io_bus
);
  localparam int ITER  = 32 / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

  state_t            r_state;
  logic [63:0]       r_hilo;
  logic [63:0]       r_partial;
  logic [63:0]       r_mcand;
  logic [31:0]       r_mplier;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_op;
  logic              r_neg;
  logic              r_busy;
  logic              r_done;

  logic              w_is_mul;
  logic              w_is_signed;
  logic [63:0]       w_step;
  logic [63:0]       w_prod;

  // Magnitude of a signed word; 0x80000000 maps to itself, which is exact as unsigned.
  function automatic logic [31:0] mag32(input logic signed [31:0] v);
    logic [31:0] u;
    u = v;
    return v[31] ? (~u + 32'd1) : u;
  endfunction

  function automatic logic [63:0] accumulate(input logic [2:0] op,
                                             input logic [63:0] hilo,
                                             input logic [63:0] prod);
    case (op)
      3'b010, 3'b110: return hilo + prod;
      3'b011, 3'b111: return hilo - prod;
      default:        return prod;
    endcase
  endfunction

  always_comb begin
    w_is_signed = (io_bus.Op == 3'b000) || (io_bus.Op == 3'b010) || (io_bus.Op == 3'b011);
`ifdef HILO_MADDU_EN
    w_is_mul    = (io_bus.Op != 3'b100) && (io_bus.Op != 3'b101);
`else
    w_is_mul    = !io_bus.Op[2];
`endif
  end

  assign w_step = r_mcand * {{(64-BITS_PER_CYCLE){1'b0}}, r_mplier[BITS_PER_CYCLE-1:0]};
  assign w_prod = r_neg ? (~r_partial + 64'd1) : r_partial;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_hilo    <= '0;
      r_partial <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_op      <= '0;
      r_neg     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (io_bus.Start) begin
            if (w_is_mul) begin
              r_op      <= io_bus.Op;
              r_neg     <= w_is_signed && (io_bus.A[31] ^ io_bus.B[31]);
              r_mcand   <= {32'd0, (w_is_signed ? mag32(io_bus.A) : io_bus.A)};
              r_mplier  <= w_is_signed ? mag32(io_bus.B) : io_bus.B;
              r_partial <= '0;
              r_cnt     <= '0;
              r_busy    <= 1'b1;
              r_state   <= MUL;
            end else if (io_bus.Op == 3'b100) begin
              r_hilo[63:32] <= io_bus.A;
            end else if (io_bus.Op == 3'b101) begin
              r_hilo[31:0]  <= io_bus.A;
            end
          end
        end
        // Retire the low multiplier digit against the multiplicand at its current weight.
        MUL: begin
          r_partial <= r_partial + w_step;
          r_mcand   <= r_mcand << BITS_PER_CYCLE;
          r_mplier  <= r_mplier >> BITS_PER_CYCLE;
          r_cnt     <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(ITER - 1)) r_state <= FIN;
        end
        FIN: begin
          r_hilo  <= accumulate(r_op, r_hilo, w_prod);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.Busy = r_busy;
  assign io_bus.Done = r_done;
  assign io_bus.Hi   = r_hilo[63:32];
  assign io_bus.Lo   = r_hilo[31:0];
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed and randomized checks of hilo_muldiv_unit against an arithmetic HI/LO model.
module tb_hilo_muldiv_unit;
  localparam int BPC  = 1;
  localparam int ITER = 32 / BPC;

  logic Clk = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;
  logic [63:0] m_hilo;

  hilo_muldiv_unit_if bus ();
  hilo_muldiv_unit_if bus4 ();

  hilo_muldiv_unit #(.BITS_PER_CYCLE(BPC)) u_dut (.Clk(Clk), .Reset(Reset), .io_bus(bus));
  hilo_muldiv_unit #(.BITS_PER_CYCLE(4))   u_dut4 (.Clk(Clk), .Reset(Reset), .io_bus(bus4));

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_mul(input logic [2:0] op);
`ifdef HILO_MADDU_EN
    return (op != 3'd4) && (op != 3'd5);
`else
    return op < 3'd4;
`endif
  endfunction

  // New {HI,LO} after one request, straight from the instruction semantics.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hilo);
    longint      sp;
    logic [63:0] up;
    sp = longint'(signed'(a)) * longint'(signed'(b));
    up = 64'(a) * 64'(b);
    case (op)
      3'd0: return sp;
      3'd1: return up;
      3'd2: return hilo + sp;
      3'd3: return hilo - sp;
      3'd4: return {a, hilo[31:0]};
      3'd5: return {hilo[63:32], a};
`ifdef HILO_MADDU_EN
      3'd6: return hilo + up;
      3'd7: return hilo - up;
`endif
      default: return hilo;
    endcase
  endfunction

  // Issues at the current negedge; returns at the negedge where the result is visible.
  task automatic exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input string tag, input int inject);
    logic [63:0] exp, old;
    int n;
    bit held;
    exp = model(op, a, b, m_hilo);
    old = m_hilo;
    bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
    @(negedge Clk);
    bus.Start = 1'b0;
    check({tag, "_done_low"}, 64'(bus.Done), 64'd0);
    if (is_mul(op)) begin
      n = 0;
      held = 1'b1;
      while (bus.Busy === 1'b1 && n < 200) begin
        n++;
        if ({bus.Hi, bus.Lo} !== old || bus.Done !== 1'b0) held = 1'b0;
        if (inject > 0 && n == inject) begin
          bus.Start = 1'b1; bus.Op = 3'b100; bus.A = 32'h1234;
        end else begin
          bus.Start = 1'b0;
        end
        @(negedge Clk);
      end
      bus.Start = 1'b0;
      check({tag, "_busy_len"}, 64'(n), 64'(ITER + 1));
      check({tag, "_held"}, 64'(held), 64'd1);
      check({tag, "_done"}, 64'(bus.Done), 64'd1);
    end else begin
      check({tag, "_busy"}, 64'(bus.Busy), 64'd0);
    end
    check({tag, "_hilo"}, {bus.Hi, bus.Lo}, exp);
    m_hilo = exp;
  endtask

  initial begin
    int n, dn;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    Reset = 1'b1;
    bus.Start = 1'b0;  bus.Op = 3'd0;  bus.A = '0;  bus.B = '0;
    bus4.Start = 1'b0; bus4.Op = 3'd0; bus4.A = '0; bus4.B = '0;
    repeat (3) @(negedge Clk);
    check("rst_hilo", {bus.Hi, bus.Lo}, 64'd0);
    check("rst_busy_done", {62'd0, bus.Busy, bus.Done}, 64'd0);
    check("rst4_state", {bus4.Hi, bus4.Lo} | 64'({bus4.Busy, bus4.Done}), 64'd0);
    Reset = 1'b0;
    m_hilo = '0;
    @(negedge Clk);

    exec(3'd0, 32'hFFFFFFFD, 32'd5, "mult_m3x5", 0);
    check("mult_m3x5_const", {bus.Hi, bus.Lo}, 64'hFFFFFFFF_FFFFFFF1);
    exec(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max", 0);
    check("multu_max_const", {bus.Hi, bus.Lo}, 64'hFFFFFFFE_00000001);
    exec(3'd0, 32'h80000000, 32'h80000000, "mult_minneg", 0);
    check("mult_minneg_const", {bus.Hi, bus.Lo}, 64'h40000000_00000000);

    exec(3'd4, 32'd0, 32'd0, "mthi0", 0);
    exec(3'd5, 32'hFFFFFFFF, 32'd0, "mtlo_ff", 0);
    exec(3'd2, 32'd2, 32'd3, "madd_2x3", 0);
    check("madd_const", {bus.Hi, bus.Lo}, 64'h00000001_00000005);
    exec(3'd4, 32'd0, 32'd0, "mthi0b", 0);
    exec(3'd5, 32'd0, 32'd0, "mtlo0", 0);
    exec(3'd3, 32'd1, 32'd1, "msub_1x1", 0);
    check("msub_const", {bus.Hi, bus.Lo}, 64'hFFFFFFFF_FFFFFFFF);

    exec(3'd0, 32'h00010003, 32'hFFFF0007, "mult_inject", 5);
    exec(3'd2, 32'h7FFFFFFF, 32'h80000000, "madd_b2b", 0);

    // Abort an in-flight multiply with reset.
    bus.Start = 1'b1; bus.Op = 3'd0; bus.A = 32'h12345678; bus.B = 32'h9ABCDEF0;
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (9) @(negedge Clk);
    check("abort_busy_before", 64'(bus.Busy), 64'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("abort_hilo", {bus.Hi, bus.Lo}, 64'd0);
    check("abort_busy", 64'(bus.Busy), 64'd0);
    dn = 0;
    repeat (40) begin
      @(negedge Clk);
      if (bus.Done === 1'b1) dn++;
    end
    check("abort_no_done", 64'(dn), 64'd0);
    m_hilo = '0;

    exec(3'd4, 32'd0, 32'd0, "mthi_u", 0);
    exec(3'd5, 32'd1, 32'd0, "mtlo_u", 0);
    exec(3'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, "op110", 0);
`ifdef HILO_MADDU_EN
    check("maddu_const", {bus.Hi, bus.Lo}, 64'hFFFFFFFE_00000002);
`else
    check("op110_const", {bus.Hi, bus.Lo}, 64'h00000000_00000001);
`endif
    exec(3'd7, 32'd3, 32'd4, "op111", 0);

    for (int i = 0; i < 12; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      exec(rop, ra, rb, $sformatf("rnd%0d_op%0d", i, rop), 0);
    end

    // Four bits per cycle: 8 iterations plus FIN.
    bus4.Start = 1'b1; bus4.Op = 3'd0; bus4.A = 32'd7; bus4.B = 32'hFFFFFFF7;
    @(negedge Clk);
    bus4.Start = 1'b0;
    n = 0;
    while (bus4.Busy === 1'b1 && n < 100) begin
      n++;
      @(negedge Clk);
    end
    check("bpc4_busy_len", 64'(n), 64'd9);
    check("bpc4_done", 64'(bus4.Done), 64'd1);
    check("bpc4_hilo", {bus4.Hi, bus4.Lo}, 64'hFFFFFFFF_FFFFFFC1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
